// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg -- shared definitions for the sequential ALU.
//   Opcode constants for alu_control and the FSM state type.
//   Optional feature macro: SEQ_ALU_MUL_EN (adds the BUSY state used by
//   the iterative multiplier; without it the state is not declared).
package seq_alu_pkg;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_MUL  = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_RSVD = 3'b101;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_SLT  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
`ifdef SEQ_ALU_MUL_EN
      ST_BUSY = 2'd1,
`endif
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul -- iterative shift-add multiplier, low WIDTH bits, unsigned.
//   clk, reset    : clock, asynchronous active-high reset
//   start         : load a/b and begin; ignored while not idle by the caller
//   a, b          : operands captured on start
//   busy          : high while the WIDTH shift-add steps are in progress
//   done          : one-cycle pulse, product final while it is high
//   product       : accumulated partial product
// Only instantiated when SEQ_ALU_MUL_EN is defined.
module seq_alu_mul #(
   parameter int WIDTH          = 32,
   parameter int MUL_CYCLES_LOG = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam logic [MUL_CYCLES_LOG-1:0] LAST = MUL_CYCLES_LOG'(WIDTH - 1);

   logic [MUL_CYCLES_LOG-1:0] cnt;
   logic [WIDTH-1:0]          acc;
   logic [WIDTH-1:0]          mcand;
   logic [WIDTH-1:0]          mplier;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
         end else if (busy) begin
            // bits shifted past WIDTH are dropped: the product wraps
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign product = acc;

endmodule

// File: rtl/seq_alu.sv
// seq_alu -- sequential ALU with valid/ready request and response handshakes.
//   clk, reset           : clock, asynchronous active-high reset
//   a, b, alu_control    : operands and opcode, captured on acceptance
//   in_valid / in_ready  : request handshake (in_ready high only in IDLE)
//   result, zero         : registered result and its zero flag
//   out_valid / out_ready: response handshake (out_valid high only in DONE)
// Optional feature macro: SEQ_ALU_MUL_EN. Defined: MUL runs on the iterative
// multiplier (latency WIDTH+1). Undefined: MUL completes in 1 cycle with 0.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int MUL_CYCLES_LOG = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alu_control,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             out_valid,
   input  logic             out_ready
);

   if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
      $error("seq_alu: WIDTH must be 8..64");
   end
   if ((1 << MUL_CYCLES_LOG) < WIDTH) begin : g_bad_log
      $error("seq_alu: 2**MUL_CYCLES_LOG must be >= WIDTH");
   end

   // single-cycle ops; MUL and the reserved code evaluate to 0 here
   function automatic logic [WIDTH-1:0] alu_eval(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [2:0]       op);
      logic signed [WIDTH-1:0] sx;
      logic signed [WIDTH-1:0] sy;
      logic [WIDTH-1:0]        r;
      sx = x;
      sy = y;
      case (op)
         OP_ADD:          r = x + y;
         OP_SUB:          r = x - y;
         OP_AND:          r = x & y;
         OP_OR:           r = x | y;
         OP_XOR:          r = x ^ y;
         OP_SLT:          r = {{(WIDTH-1){1'b0}}, (sx < sy)};
         OP_MUL, OP_RSVD: r = '0;
         default:         r = '0;
      endcase
      return r;
   endfunction

   state_t           state;
   logic [WIDTH-1:0] alu_res;
   logic             accept;

   always_comb alu_res = alu_eval(a, b, alu_control);
   assign accept = in_valid && in_ready;

`ifdef SEQ_ALU_MUL_EN
   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   assign mul_start = accept && (alu_control == OP_MUL);

   seq_alu_mul #(
      .WIDTH          (WIDTH),
      .MUL_CYCLES_LOG (MUL_CYCLES_LOG)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         result    <= '0;
         zero      <= 1'b1;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  in_ready <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
                  if (alu_control == OP_MUL) begin
                     state <= ST_BUSY;
                  end else begin
                     state     <= ST_DONE;
                     result    <= alu_res;
                     zero      <= ~|alu_res;
                     out_valid <= 1'b1;
                  end
`else
                  state     <= ST_DONE;
                  result    <= alu_res;
                  zero      <= ~|alu_res;
                  out_valid <= 1'b1;
`endif
               end
            end
`ifdef SEQ_ALU_MUL_EN
            ST_BUSY: begin
               // done pulses the cycle after the last step, with busy already low
               if (mul_done && !mul_busy) begin
                  state     <= ST_DONE;
                  result    <= mul_product;
                  zero      <= ~|mul_product;
                  out_valid <= 1'b1;
               end
            end
`endif
            ST_DONE: begin
               // in_ready stays low on this edge, so nothing is accepted here
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu -- directed bench for seq_alu at WIDTH=32 and WIDTH=8.
// MUL expectations follow whether SEQ_ALU_MUL_EN is defined.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] a, b, result;
   logic [2:0]  op;
   logic        in_valid, in_ready, zero, out_valid, out_ready;
   logic [7:0]  a8, b8, result8;
   logic [2:0]  op8;
   logic        in_valid8, in_ready8, zero8, out_valid8, out_ready8;

   int n_asserts = 0;
   int n_fail    = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(32), .MUL_CYCLES_LOG(5)) dut32 (
      .clk(clk), .reset(reset), .a(a), .b(b), .alu_control(op),
      .in_valid(in_valid), .in_ready(in_ready), .result(result), .zero(zero),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   seq_alu #(.WIDTH(8), .MUL_CYCLES_LOG(3)) dut8 (
      .clk(clk), .reset(reset), .a(a8), .b(b8), .alu_control(op8),
      .in_valid(in_valid8), .in_ready(in_ready8), .result(result8), .zero(zero8),
      .out_valid(out_valid8), .out_ready(out_ready8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // call between edges; the request is accepted on the next rising edge
   task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic send8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      op8 = o; a8 = x; b8 = y; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
   endtask

   task automatic drain8();
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      a = '0; b = '0; op = '0; in_valid = 1'b0; out_ready = 1'b0;
      a8 = '0; b8 = '0; op8 = '0; in_valid8 = 1'b0; out_ready8 = 1'b0;

      // reset values
      #12;
      check("rst_result", result, 32'h0);
      check("rst_zero", zero, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);

      // ADD wrap, accepted on the first edge after reset release
      @(negedge clk);
      reset = 1'b0;
      send(3'b010, 32'hFFFF_FFFF, 32'h1);
      check("add_out_valid", out_valid, 1'b1);
      check("add_result", result, 32'h0);
      check("add_zero", zero, 1'b1);
      check("add_in_ready", in_ready, 1'b0);
      drain();
      check("add_drain_out_valid", out_valid, 1'b0);
      check("add_drain_in_ready", in_ready, 1'b1);

      // SLT signed both ways
      send(3'b111, 32'hFFFF_FFFE, 32'h1);
      check("slt_neg_lt", result, 32'h1);
      check("slt_neg_zero", zero, 1'b0);
      drain();
      send(3'b111, 32'h1, 32'hFFFF_FFFE);
      check("slt_swapped", result, 32'h0);
      check("slt_swapped_zero", zero, 1'b1);
      drain();

      // logic ops and reserved code
      send(3'b001, 32'h0000_00F0, 32'h0000_000F);
      check("or", result, 32'hFF);
      drain();
      send(3'b100, 32'h0000_00FF, 32'h0000_000F);
      check("xor", result, 32'hF0);
      drain();
      send(3'b101, 32'h1234_5678, 32'h1111_1111);
      check("rsvd_result", result, 32'h0);
      check("rsvd_zero", zero, 1'b1);
      drain();

      // SUB held under back-pressure while inputs toggle and in_valid is asserted
      send(3'b110, 32'd5, 32'd7);
      for (int i = 0; i < 5; i++) begin
         a = 32'hA5A5_0000 + i; b = ~a; op = 3'b000; in_valid = 1'b1;
         @(posedge clk); #1;
         check("sub_hold_result", result, 32'hFFFF_FFFE);
         check("sub_hold_valid", out_valid, 1'b1);
         check("sub_hold_in_ready", in_ready, 1'b0);
      end

      // response edge with a request pending: not accepted on that edge
      op = 3'b010; a = 32'd1; b = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("done_exit_no_accept_valid", out_valid, 1'b0);
      check("done_exit_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("next_accept_valid", out_valid, 1'b1);
      check("next_accept_result", result, 32'd2);
      drain();

`ifdef SEQ_ALU_MUL_EN
      // iterative MUL, latency 33, in_ready low throughout
      send(3'b011, 32'h0001_0000, 32'h0001_0003);
      check("mul_c0_valid", out_valid, 1'b0);
      for (int i = 1; i <= 32; i++) begin
         @(posedge clk); #1;
         check("mul_busy_valid", out_valid, 1'b0);
         check("mul_busy_in_ready", in_ready, 1'b0);
      end
      @(posedge clk); #1;
      check("mul_done_valid", out_valid, 1'b1);
      check("mul_result", result, 32'h0003_0000);
      drain();

      // reset mid-MUL
      send(3'b011, 32'h0001_0000, 32'h0001_0003);
      for (int i = 1; i < 10; i++) begin
         @(posedge clk);
      end
      #1;
`else
      // MUL without the multiplier: one cycle, result 0
      send(3'b011, 32'd3, 32'd4);
      check("mul_off_valid", out_valid, 1'b1);
      check("mul_off_result", result, 32'h0);
      check("mul_off_zero", zero, 1'b1);
      drain();

      // reset while holding a nonzero result
      send(3'b010, 32'd1, 32'd1);
      check("pre_reset_result", result, 32'd2);
      @(posedge clk); #1;
`endif
      reset = 1'b1;
      #1;
      check("async_rst_result", result, 32'h0);
      check("async_rst_zero", zero, 1'b1);
      check("async_rst_out_valid", out_valid, 1'b0);
      check("async_rst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      send(3'b000, 32'h0000_00F0, 32'h0000_003C);
      check("and_after_rst_valid", out_valid, 1'b1);
      check("and_after_rst", result, 32'h30);
      drain();

      // WIDTH=8 instance
      send8(3'b010, 8'd200, 8'd100);
      check("w8_add_valid", out_valid8, 1'b1);
      check("w8_add_result", result8, 8'd44);
      drain8();
`ifdef SEQ_ALU_MUL_EN
      send8(3'b011, 8'd3, 8'd4);
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         check("w8_mul_busy_valid", out_valid8, 1'b0);
      end
      @(posedge clk); #1;
      check("w8_mul_valid", out_valid8, 1'b1);
      check("w8_mul_result", result8, 8'd12);
      drain8();
`else
      send8(3'b011, 8'd3, 8'd4);
      check("w8_mul_valid", out_valid8, 1'b1);
      check("w8_mul_result", result8, 8'd0);
      check("w8_mul_zero", zero8, 1'b1);
      drain8();
`endif
      check("w8_idle_in_ready", in_ready8, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
